// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns engine: one valid/ready
// channel carrying the input state and mode, one carrying the result.
interface mix_columns_seq_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;

   // Producer/consumer side of the engine.
   modport master (
      output in_valid, in_state, in_inv, out_ready,
      input  in_ready, out_valid, out_state
   );

   // The engine itself.
   modport slave (
      input  in_valid, in_state, in_inv, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine. A 128-bit state is
// latched on the input handshake, transformed COLS_PER_CYCLE columns per
// clock, then held on the output channel until the consumer takes it.
module mix_columns_seq #(
   parameter int unsigned COLS_PER_CYCLE = 1,
   parameter logic [8:0]  POLY           = 9'h11B,
   parameter bit          INV_EN         = 1'b1
) (
   input logic              clk,
   input logic              rst,
   mix_columns_seq_if.slave bus
);

   // Illegal configurations stop elaboration instead of building a
   // datapath that silently skips or repeats columns.
   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end
   if (POLY[8] != 1'b1) begin : g_bad_poly
      $error("mix_columns_seq: POLY must have bit 8 set");
   end

   // Number of RUN cycles per block; guarded so a bad parameter reaches
   // the elaboration error above rather than a divide by zero.
   localparam int unsigned NUM_STEPS = (COLS_PER_CYCLE == 0) ? 1 : 4 / COLS_PER_CYCLE;
   localparam logic [1:0]  LAST_STEP = 2'(NUM_STEPS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   // Multiply by 02 in GF(2^8), reducing by the configured polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? POLY[7:0] : 8'h00);
   endfunction

   // Transform one column (row 0 in the top byte). All constants are
   // sums of the x, 2x, 4x, 8x chain, so each byte needs three xtimes.
   function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
      logic [7:0]  a  [4];
      logic [7:0]  x2 [4];
      logic [7:0]  x4 [4];
      logic [7:0]  x8 [4];
      logic [7:0]  b;
      logic [31:0] res;
      res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31 - 8*i -: 8];
         x2[i] = xtime(a[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
      end
      for (int i = 0; i < 4; i++) begin
         if (inv) begin
            // 0E*a_i ^ 0B*a_(i+1) ^ 0D*a_(i+2) ^ 09*a_(i+3)
            b = (x8[i]         ^ x4[i]         ^ x2[i])
              ^ (x8[(i+1) % 4] ^ x2[(i+1) % 4] ^ a[(i+1) % 4])
              ^ (x8[(i+2) % 4] ^ x4[(i+2) % 4] ^ a[(i+2) % 4])
              ^ (x8[(i+3) % 4] ^ a[(i+3) % 4]);
         end else begin
            // 02*a_i ^ 03*a_(i+1) ^ a_(i+2) ^ a_(i+3)
            b = x2[i]
              ^ (x2[(i+1) % 4] ^ a[(i+1) % 4])
              ^ a[(i+2) % 4]
              ^ a[(i+3) % 4];
         end
         res[31 - 8*i -: 8] = b;
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [3:0][31:0] work_q,  work_d;   // work_q[3] is column 0
   logic [1:0]       cnt_q,   cnt_d;
   logic             mode_q,  mode_d;
   logic [1:0]       col;
   logic             accept;
   logic             result_valid;
   logic [127:0]     result;

   // State, working register, step counter and latched mode.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (rst) begin
         // NOTE: the working register is cleared too; it is a plain
         // register, not a memory, and out_state must read as zero.
         state_q <= S_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      state_d      = state_q;
      work_d       = work_q;
      cnt_d        = cnt_q;
      mode_d       = mode_q;
      col          = '0;
      accept       = 1'b0;
      result_valid = 1'b0;
      result       = '0;

      unique case (state_q)
         S_IDLE: begin
            accept = 1'b1;
            if (bus.in_valid) begin
               work_d  = bus.in_state;
               mode_d  = bus.in_inv & INV_EN;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // One transformer per slot; each slot picks its column through
            // a small mux driven by the step counter.
            for (int k = 0; k < COLS_PER_CYCLE; k++) begin
               col = 2'(int'(cnt_q) * COLS_PER_CYCLE + k);
               work_d[2'd3 - col] = mix_column(work_q[2'd3 - col], mode_q);
            end
            if (cnt_q == LAST_STEP) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end

         S_DONE: begin
            result_valid = 1'b1;
            result       = work_q;
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // in_ready depends on state only, never on out_ready.
   assign bus.in_ready  = accept;
   assign bus.out_valid = result_valid;
   assign bus.out_state = result;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq: FIPS-197 vectors, column vectors,
// latency per configuration, backpressure, mid-run reset and a random
// stream against an independent GF(2^8) reference model.
module tb_mix_columns_seq;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] COL1_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] COL1_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
   localparam logic [127:0] COL2_IN  = 128'hd4d4d4d52d26314c01010101c6c6c6c6;
   localparam logic [127:0] COL2_OUT = 128'hd5d5d7d64d7ebdf801010101c6c6c6c6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance 0: 1 col/cycle, inverse enabled. 1: 1 col/cycle, inverse
   // disabled. 2: 4 col/cycle. 3: 2 col/cycle.
   logic         drv_valid [4];
   logic         drv_inv   [4];
   logic         drv_ready [4];
   logic [127:0] drv_state [4];
   logic         mon_in_ready  [4];
   logic         mon_out_valid [4];
   logic [127:0] mon_out_state [4];

   mix_columns_seq_if bus [4] ();

   for (genvar i = 0; i < 4; i++) begin : g_hook
      assign bus[i].in_valid  = drv_valid[i];
      assign bus[i].in_inv    = drv_inv[i];
      assign bus[i].in_state  = drv_state[i];
      assign bus[i].out_ready = drv_ready[i];
      assign mon_in_ready[i]  = bus[i].in_ready;
      assign mon_out_valid[i] = bus[i].out_valid;
      assign mon_out_state[i] = bus[i].out_state;
   end

   mix_columns_seq #(.COLS_PER_CYCLE(1), .POLY(9'h11B), .INV_EN(1'b1)) u_c1_inv (
      .clk(clk), .rst(rst), .bus(bus[0]));
   mix_columns_seq #(.COLS_PER_CYCLE(1), .POLY(9'h11B), .INV_EN(1'b0)) u_c1_fwd (
      .clk(clk), .rst(rst), .bus(bus[1]));
   mix_columns_seq #(.COLS_PER_CYCLE(4), .POLY(9'h11B), .INV_EN(1'b1)) u_c4 (
      .clk(clk), .rst(rst), .bus(bus[2]));
   mix_columns_seq #(.COLS_PER_CYCLE(2), .POLY(9'h11B), .INV_EN(1'b1)) u_c2 (
      .clk(clk), .rst(rst), .bus(bus[3]));

   // Shift-and-add GF(2^8) multiply with long-division reduction.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   // Matrix form of MixColumns / InvMixColumns over the whole state.
   function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   b;
      logic [127:0] r;
      r = '0;
      if (inv) begin
         coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
      end
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) a[i] = s[127 - 8*(4*c + i) -: 8];
         for (int i = 0; i < 4; i++) begin
            b = '0;
            for (int j = 0; j < 4; j++) b = b ^ gmul(coef[j], a[(i + j) % 4]);
            r[127 - 8*(4*c + i) -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one block and hold it for exactly the accepting edge; the
   // inputs are then scrambled to show they no longer matter.
   task automatic send(input int idx, input logic [127:0] s, input logic inv);
      int n;
      n = 0;
      while (!mon_in_ready[idx] && n < 50) begin
         step();
         n++;
      end
      check("send_ready", 128'(mon_in_ready[idx]), 128'(1));
      drv_state[idx] = s;
      drv_inv[idx]   = inv;
      drv_valid[idx] = 1'b1;
      step();
      drv_valid[idx] = 1'b0;
      drv_state[idx] = {$urandom, $urandom, $urandom, $urandom};
      drv_inv[idx]   = ~inv;
   endtask

   // Edges from acceptance until out_valid is seen (bounded).
   task automatic wait_out(input int idx, output int lat);
      lat = 0;
      while (!mon_out_valid[idx] && lat < 50) begin
         step();
         lat++;
      end
   endtask

   // Check the result, complete the output handshake and check the return
   // to IDLE on the following edge.
   task automatic take(input int idx, input string tag, input logic [127:0] exp);
      check(tag, mon_out_state[idx], exp);
      drv_ready[idx] = 1'b1;
      step();
      drv_ready[idx] = 1'b0;
      check({tag, "_valid_drop"}, 128'(mon_out_valid[idx]), 128'(0));
      check({tag, "_ready_back"}, 128'(mon_in_ready[idx]), 128'(1));
   endtask

   initial begin
      int           lat;
      logic [127:0] exp_q [$];
      logic [127:0] pst;
      logic         pinv;
      logic         pending;
      logic         fire_in;
      logic         fire_out;
      int           sent;
      int           rcvd;
      int           cyc;

      for (int i = 0; i < 4; i++) begin
         drv_valid[i] = 1'b0;
         drv_inv[i]   = 1'b0;
         drv_ready[i] = 1'b0;
         drv_state[i] = '0;
      end

      // Reset state of every instance.
      rst = 1'b1;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         check("rst_in_ready",  128'(mon_in_ready[i]),  128'(1));
         check("rst_out_valid", 128'(mon_out_valid[i]), 128'(0));
         check("rst_out_state", mon_out_state[i], '0);
      end
      rst = 1'b0;
      step();

      // Forward, 1 col/cycle: result exactly 4 edges after acceptance.
      send(0, FIPS_IN, 1'b0);
      wait_out(0, lat);
      check("lat_c1", 128'(lat), 128'(4));
      take(0, "fwd_c1", FIPS_OUT);

      // Inverse of the same vector back to the original.
      send(0, FIPS_OUT, 1'b1);
      wait_out(0, lat);
      check("lat_c1_inv", 128'(lat), 128'(4));
      take(0, "inv_c1", FIPS_IN);

      // Inverse disabled: in_inv ignored, forward result produced.
      send(1, FIPS_OUT, 1'b1);
      wait_out(1, lat);
      take(1, "inv_disabled", ref_mix(FIPS_OUT, 1'b0));

      // Four columns per cycle: latency 1.
      send(2, COL1_IN, 1'b0);
      wait_out(2, lat);
      check("lat_c4", 128'(lat), 128'(1));
      take(2, "fwd_c4_v1", COL1_OUT);
      send(2, COL2_IN, 1'b0);
      wait_out(2, lat);
      check("lat_c4_v2", 128'(lat), 128'(1));
      take(2, "fwd_c4_v2", COL2_OUT);
      send(2, COL2_OUT, 1'b1);
      wait_out(2, lat);
      take(2, "inv_c4", COL2_IN);

      // Two columns per cycle: latency 2.
      send(3, FIPS_IN, 1'b0);
      wait_out(3, lat);
      check("lat_c2", 128'(lat), 128'(2));
      take(3, "fwd_c2", FIPS_OUT);

      // Backpressure: result held, no acceptance while DONE.
      send(0, COL1_IN, 1'b0);
      wait_out(0, lat);
      for (int i = 0; i < 10; i++) begin
         check("bp_state", mon_out_state[0], COL1_OUT);
         check("bp_valid", 128'(mon_out_valid[0]), 128'(1));
         check("bp_in_ready", 128'(mon_in_ready[0]), 128'(0));
         drv_valid[0] = (i % 2 == 0);
         drv_state[0] = FIPS_IN;
         drv_inv[0]   = 1'b0;
         step();
      end
      drv_valid[0] = 1'b0;
      take(0, "bp_release", COL1_OUT);
      repeat (6) step();
      check("bp_no_ghost", 128'(mon_out_valid[0]), 128'(0));

      // Reset while in RUN with cnt = 2.
      send(0, FIPS_IN, 1'b0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", 128'(mon_out_valid[0]), 128'(0));
      check("midrst_state", mon_out_state[0], '0);
      check("midrst_ready", 128'(mon_in_ready[0]), 128'(1));
      repeat (6) step();
      check("midrst_no_partial", 128'(mon_out_valid[0]), 128'(0));
      send(0, COL2_IN, 1'b0);
      wait_out(0, lat);
      check("lat_after_rst", 128'(lat), 128'(4));
      take(0, "after_rst", COL2_OUT);

      // Random stream with gaps on both sides, 2 cols/cycle.
      sent    = 0;
      rcvd    = 0;
      cyc     = 0;
      pending = 1'b0;
      pst     = '0;
      pinv    = 1'b0;
      while ((sent < 1000 || rcvd < 1000) && cyc < 40000) begin
         if (!pending && sent < 1000 && $urandom_range(0, 3) != 0) begin
            pending = 1'b1;
            pst     = {$urandom, $urandom, $urandom, $urandom};
            pinv    = 1'($urandom_range(0, 1));
         end
         drv_valid[3] = pending;
         drv_state[3] = pending ? pst : {$urandom, $urandom, $urandom, $urandom};
         drv_inv[3]   = pending ? pinv : 1'($urandom_range(0, 1));
         drv_ready[3] = ($urandom_range(0, 2) != 0);
         fire_in  = pending && mon_in_ready[3];
         fire_out = drv_ready[3] && mon_out_valid[3];
         if (fire_out) begin
            if (exp_q.size() > 0) check("stream_out", mon_out_state[3], exp_q.pop_front());
            else                  check("stream_extra", mon_out_state[3], 'x);
         end
         step();
         cyc++;
         if (fire_in) begin
            exp_q.push_back(ref_mix(pst, pinv));
            pending = 1'b0;
            sent++;
         end
         if (fire_out) rcvd++;
      end
      drv_valid[3] = 1'b0;
      drv_ready[3] = 1'b0;
      check("stream_count", 128'(rcvd), 128'(1000));
      check("stream_left", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
